regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file (1 write, 2 read, x0 hard-wired zero) between two requesters.
  - Main pipeline writeback stage.
  - Long-latency multiply/divide unit (MDU).
- MDU results are buffered in a small FIFO and drained when the pipeline leaves the port idle.
- A starvation counter forces a drain by stalling the pipeline writeback.
- Sits between writeback muxing and the register file write inputs.

Parameters:
- DEPTH, 2, MDU result FIFO entries; power of two, >=2.
- MAX_WAIT, 3, cycles a non-empty FIFO head may be denied before a forced grant; >=1.
- DATA_WIDTH, 32, write data width.
- ADDR_WIDTH, 5, register index width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous active-high reset.
- pipe_wb_valid  input  1  pipeline has a writeback this cycle.
- pipe_wb_rd  input  ADDR_WIDTH  pipeline destination register.
- pipe_wb_data  input  DATA_WIDTH  pipeline write data.
- pipe_stall  output  1  pipeline writeback denied; pipeline must hold rd/data and valid next cycle.
- mdu_valid  input  1  MDU result available.
- mdu_rd  input  ADDR_WIDTH  MDU destination register.
- mdu_data  input  DATA_WIDTH  MDU result.
- mdu_ready  output  1  FIFO can accept; transfer when mdu_valid && mdu_ready.
- rf_we  output  1  register file write enable.
- rf_rd  output  ADDR_WIDTH  register file write address.
- rf_wd  output  DATA_WIDTH  register file write data.
- fifo_count  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- State: FIFO storage, read/write pointers, count, starve_cnt (0..MAX_WAIT). All reset asynchronously: count=0, pointers=0, starve_cnt=0. FIFO data is not reset.
- While rst=1: mdu_ready=0, rf_we=0, pipe_stall=0, fifo_count=0. rf_rd/rf_wd are don't-care while rf_we=0.
- mdu_ready = !rst && (count < DEPTH). No push-through when full: a pop in the same cycle does not raise mdu_ready.
- Push: on mdu_valid && mdu_ready, {mdu_rd, mdu_data} is written at the tail.
  - MDU results with mdu_rd==0 are accepted but not stored (count unchanged).
- Pipeline effective request: pipe_req = pipe_wb_valid && pipe_wb_rd != 0. A pipeline write to x0 never uses the port and is never stalled.
- Grant (combinational, same cycle):
  - fifo_grant = (count != 0) && (!pipe_req || starve_cnt == MAX_WAIT).
  - pipe_grant = pipe_req && !fifo_grant.
  - pipe_stall = pipe_req && fifo_grant.
- Write port:
  - fifo_grant: rf_we=1, rf_rd/rf_wd = FIFO head; head popped at posedge.
  - pipe_grant: rf_we=1, rf_rd/rf_wd = pipe inputs.
  - Otherwise rf_we=0.
- starve_cnt update:
  - Cleared on fifo_grant or when count==0.
  - Incremented, saturating at MAX_WAIT, when count!=0 and the head is not granted.
- Latency: an MDU result accepted at edge N is written to the register file at the earliest in cycle N+1, never in the acceptance cycle.
- Simultaneous push and pop: both occur; count unchanged; pointers advance modulo DEPTH (wrap-around).
- Ordering: FIFO entries are written strictly in arrival order.
  - No ordering is enforced between pipeline and MDU writes to the same rd; the issue logic guarantees no WAW overlap.
- Reset mid-operation: buffered entries are discarded; no partial write occurs after rst rises.
- pipe_stall is asserted for at most one cycle per forced grant. After a forced grant starve_cnt=0, so the pipeline wins the next MAX_WAIT contested cycles.

Test Plan:
- Reset, then mdu_valid=1, rd=5, data=0x1234, pipe idle -> mdu_ready=1. Next cycle: rf_we=1, rf_rd=5, rf_wd=0x1234, fifo_count=1 then 0.
- Pipe writes rd=3 continuously; MDU pushes rd=7 -> pipe granted 3 cycles (starve_cnt 1,2,3). In the 4th cycle: rf_rd=7, pipe_stall=1. The following cycle the pipe's rd=3 is written.
- MDU pushes 3 results back-to-back while the pipe is busy -> first two accepted. mdu_ready=0 when fifo_count=2. Third is held until after a pop. Drain order is rd 10, 11, 12.
- MDU result with rd=0 -> accepted, fifo_count stays 0, rf_we never asserted. Pipe write to rd=0 with FIFO full -> pipe_stall=0, FIFO head written.
- Push and forced pop in the same cycle at count=1 -> count stays 1. Pointer wraps correctly over 8+ transactions with DEPTH=2; data matches a scoreboard.
- Assert rst with fifo_count=2 mid-stream -> rf_we=0, mdu_ready=0 immediately (asynchronous). After release, fifo_count=0 and no stale write appears.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between the pipeline writeback and
// a FIFO of buffered MDU results, with a starvation counter forcing MDU drains.
module regfile_wb_arbiter #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned MAX_WAIT   = 3,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       pipe_wb_valid,
  input  logic [ADDR_WIDTH-1:0]      pipe_wb_rd,
  input  logic [DATA_WIDTH-1:0]      pipe_wb_data,
  output logic                       pipe_stall,
  input  logic                       mdu_valid,
  input  logic [ADDR_WIDTH-1:0]      mdu_rd,
  input  logic [DATA_WIDTH-1:0]      mdu_data,
  output logic                       mdu_ready,
  output logic                       rf_we,
  output logic [ADDR_WIDTH-1:0]      rf_rd,
  output logic [DATA_WIDTH-1:0]      rf_wd,
  output logic [$clog2(DEPTH):0]     fifo_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned SW = $clog2(MAX_WAIT + 1);
  localparam int unsigned EW = ADDR_WIDTH + DATA_WIDTH;

  logic [EW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;

  logic pipe_req;
  logic push;
  logic store;
  logic fifo_grant;
  logic pipe_grant;
  logic [EW-1:0] head;

  assign head      = mem_q[rd_ptr_q];
  assign pipe_req  = pipe_wb_valid && (pipe_wb_rd != '0);
  assign mdu_ready = !rst && (count_q < CW'(DEPTH));
  assign push      = mdu_valid && mdu_ready;
  // x0 results complete the handshake but never occupy a slot
  assign store     = push && (mdu_rd != '0);

  assign fifo_grant = !rst && (count_q != '0) &&
                      (!pipe_req || (starve_q == SW'(MAX_WAIT)));
  assign pipe_grant = !rst && pipe_req && !fifo_grant;
  assign pipe_stall = pipe_req && fifo_grant;
  assign fifo_count = count_q;

  always_comb begin
    rf_we = 1'b0;
    rf_rd = '0;
    rf_wd = '0;
    if (fifo_grant) begin
      rf_we = 1'b1;
      rf_rd = head[EW-1:DATA_WIDTH];
      rf_wd = head[DATA_WIDTH-1:0];
    end else if (pipe_grant) begin
      rf_we = 1'b1;
      rf_rd = pipe_wb_rd;
      rf_wd = pipe_wb_data;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    if (store) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (fifo_grant) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (store && !fifo_grant) begin
      count_d = count_q + CW'(1);
    end else if (!store && fifo_grant) begin
      count_d = count_q - CW'(1);
    end
    if (fifo_grant || (count_q == '0)) begin
      starve_d = '0;
    end else if (starve_q != SW'(MAX_WAIT)) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[wr_ptr_q] <= {mdu_rd, mdu_data};
    end
  end

endmodule
